// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: opcodes, sequencing-FSM
// state encoding and performance-counter width.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int CNT_W = 16;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } hz_state_e;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard classifier: returns the number of stall cycles the
// instruction in ID needs given the EX and MEM destinations.
module hazard_detect
    import mips_pkg::*;
(
    input  logic       id_valid,
    input  logic [5:0] id_op,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_wr_reg,
    input  logic       mem_mem_read,
    input  logic [4:0] mem_wr_reg,
    output logic [1:0] stall_len
);

    logic uses_rs;
    logic uses_rt;
    logic is_branch;
    logic match_ex;
    logic match_mem;

    assign uses_rs   = !(id_op == OP_J || id_op == OP_JAL || id_op == OP_LUI);
    assign uses_rt   = (id_op == OP_RTYPE) || (id_op == OP_BEQ) ||
                       (id_op == OP_BNE)   || (id_op == OP_SW);
    assign is_branch = (id_op == OP_BEQ) || (id_op == OP_BNE);

    // $0 is hardwired to zero, so a write to it can never create a dependency.
    assign match_ex  = (ex_wr_reg != 5'd0) &&
                       ((uses_rs && id_rs == ex_wr_reg) || (uses_rt && id_rt == ex_wr_reg));
    assign match_mem = (mem_wr_reg != 5'd0) &&
                       ((uses_rs && id_rs == mem_wr_reg) || (uses_rt && id_rt == mem_wr_reg));

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        stall_len = 2'd0;
        if (id_valid) begin
            if (is_branch && match_ex && ex_mem_read) begin
                stall_len = 2'd2;
            end else if (is_branch && ((match_ex && ex_reg_write) || (match_mem && mem_mem_read))) begin
                stall_len = 2'd1;
            end else if (!is_branch && match_ex && ex_mem_read) begin
                stall_len = 2'd1;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: RUN/HOLD stall FSM, branch/jump resolution
// in ID and saturating stall/flush performance counters.
module hazard_ctrl
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       id_op,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             branch_equal,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_wr_reg,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_wr_reg,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             branch_taken,
    output logic             jump_taken,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [1:0]       stall_len;
    logic             stall;

    hazard_detect u_detect (
        .id_valid     (id_valid),
        .id_op        (id_op),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_wr_reg    (ex_wr_reg),
        .mem_mem_read (mem_mem_read),
        .mem_wr_reg   (mem_wr_reg),
        .stall_len    (stall_len)
    );

    // Mealy outputs; reset is folded in so the pipeline is frozen while rst is low.
    always_comb begin
        state_d      = state_q;
        stall        = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        branch_taken = 1'b0;
        jump_taken   = 1'b0;

        if (!rst) begin
            state_d     = ST_RUN;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (state_q == ST_HOLD) begin
            stall   = 1'b1;
            state_d = ST_RUN;
        end else if (stall_len != 2'd0) begin
            stall   = 1'b1;
            state_d = (stall_len == 2'd2) ? ST_HOLD : ST_RUN;
        end else if (id_valid) begin
            if ((id_op == OP_BEQ && branch_equal) || (id_op == OP_BNE && !branch_equal)) begin
                branch_taken = 1'b1;
                ifid_flush   = 1'b1;
            end else if (id_op == OP_J || id_op == OP_JAL) begin
                jump_taken = 1'b1;
                ifid_flush = 1'b1;
            end
        end

        if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall      ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = ifid_flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; control outputs are compared
// as one packed vector {pc_write, ifid_write, ifid_flush, idex_bubble, branch_taken, jump_taken}.
module tb_hazard_ctrl;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] O_RST   = 6'b000100;
    localparam logic [5:0] O_RUN   = 6'b110000;
    localparam logic [5:0] O_STALL = 6'b000100;
    localparam logic [5:0] O_BR    = 6'b111010;
    localparam logic [5:0] O_JMP   = 6'b111001;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [5:0]  id_op;
    logic [4:0]  id_rs, id_rt;
    logic        branch_equal;
    logic        ex_mem_read, ex_reg_write;
    logic [4:0]  ex_wr_reg;
    logic        mem_mem_read;
    logic [4:0]  mem_wr_reg;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, branch_taken, jump_taken;
    logic [15:0] stall_cycles, flush_count;
    logic [5:0]  outs;

    int tests = 0;
    int failures = 0;

    assign outs = {pc_write, ifid_write, ifid_flush, idex_bubble, branch_taken, jump_taken};

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_op        (id_op),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .branch_equal (branch_equal),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_wr_reg    (ex_wr_reg),
        .mem_mem_read (mem_mem_read),
        .mem_wr_reg   (mem_wr_reg),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .branch_taken (branch_taken),
        .jump_taken   (jump_taken),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid     = 1'b0;
        id_op        = OP_RTYPE;
        id_rs        = 5'd0;
        id_rt        = 5'd0;
        branch_equal = 1'b0;
        ex_mem_read  = 1'b0;
        ex_reg_write = 1'b0;
        ex_wr_reg    = 5'd0;
        mem_mem_read = 1'b0;
        mem_wr_reg   = 5'd0;
    endtask

    task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        id_valid = 1'b1;
        id_op    = op;
        id_rs    = rs;
        id_rt    = rt;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        #3;
        tick();
        tests++;
        if (outs !== O_RST) begin
            failures++;
            $display("FAIL reset_outs: got %b want %b", outs, O_RST);
        end
        tests++;
        if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_count);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (outs !== O_RUN) begin
            failures++;
            $display("FAIL idle_after_reset: got %b want %b", outs, O_RUN);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(OP_RTYPE, 5'd8, 5'd1);
        ex_mem_read = 1'b1;  ex_wr_reg = 5'd8;
        #1;
        tests++;
        if (outs !== O_STALL) begin
            failures++;
            $display("FAIL load_use_stall: got %b want %b", outs, O_STALL);
        end
        tick();
        ex_mem_read = 1'b0;  ex_wr_reg = 5'd0;
        mem_mem_read = 1'b1; mem_wr_reg = 5'd8;
        #1;
        tests++;
        if (outs !== O_RUN) begin
            failures++;
            $display("FAIL load_use_release: got %b want %b", outs, O_RUN);
        end
        tests++;
        if (stall_cycles !== 16'd1) begin
            failures++;
            $display("FAIL load_use_count: got %0d want 1", stall_cycles);
        end
        // sw uses rt; lui does not use rs.
        clear_inputs();
        set_id(OP_SW, 5'd2, 5'd8);
        ex_mem_read = 1'b1;  ex_wr_reg = 5'd8;
        #1;
        tests++;
        if (outs !== O_STALL) begin
            failures++;
            $display("FAIL sw_rt_stall: got %b want %b", outs, O_STALL);
        end
        set_id(OP_LUI, 5'd8, 5'd1);
        #1;
        tests++;
        if (outs !== O_RUN) begin
            failures++;
            $display("FAIL lui_no_rs: got %b want %b", outs, O_RUN);
        end
    endtask

    task automatic test_load_branch();
        do_reset();
        set_id(OP_BEQ, 5'd9, 5'd2);
        branch_equal = 1'b1;
        ex_mem_read = 1'b1;  ex_wr_reg = 5'd9;
        #1;
        tests++;
        if (outs !== O_STALL) begin
            failures++;
            $display("FAIL load_branch_stall1: got %b want %b", outs, O_STALL);
        end
        tick();
        // Second cycle must stall purely because of HOLD: no hazard visible.
        ex_mem_read = 1'b0;  ex_wr_reg = 5'd0;
        #1;
        tests++;
        if (outs !== O_STALL) begin
            failures++;
            $display("FAIL load_branch_hold: got %b want %b", outs, O_STALL);
        end
        tick();
        #1;
        tests++;
        if (outs !== O_BR) begin
            failures++;
            $display("FAIL load_branch_taken: got %b want %b", outs, O_BR);
        end
        tick();
        clear_inputs();
        #1;
        tests++;
        if (stall_cycles !== 16'd2 || flush_count !== 16'd1) begin
            failures++;
            $display("FAIL load_branch_counts: got %0d/%0d want 2/1", stall_cycles, flush_count);
        end
    endtask

    task automatic test_alu_branch();
        do_reset();
        set_id(OP_BNE, 5'd1, 5'd3);
        branch_equal = 1'b1;
        ex_reg_write = 1'b1; ex_wr_reg = 5'd3;
        #1;
        tests++;
        if (outs !== O_STALL) begin
            failures++;
            $display("FAIL alu_branch_stall: got %b want %b", outs, O_STALL);
        end
        tick();
        ex_reg_write = 1'b0; ex_wr_reg = 5'd0;
        mem_wr_reg = 5'd3;
        #1;
        tests++;
        if (outs !== O_RUN) begin
            failures++;
            $display("FAIL bne_not_taken: got %b want %b", outs, O_RUN);
        end
        tick();
        tests++;
        if (stall_cycles !== 16'd1 || flush_count !== 16'd0) begin
            failures++;
            $display("FAIL alu_branch_counts: got %0d/%0d want 1/0", stall_cycles, flush_count);
        end
        // Branch on MEM-stage load needs exactly one cycle.
        set_id(OP_BEQ, 5'd4, 5'd5);
        branch_equal = 1'b0;
        mem_mem_read = 1'b1; mem_wr_reg = 5'd4;
        #1;
        tests++;
        if (outs !== O_STALL) begin
            failures++;
            $display("FAIL mem_load_branch_stall: got %b want %b", outs, O_STALL);
        end
        tick();
        mem_mem_read = 1'b0; mem_wr_reg = 5'd0;
        #1;
        tests++;
        if (outs !== O_RUN) begin
            failures++;
            $display("FAIL mem_load_branch_one: got %b want %b", outs, O_RUN);
        end
    endtask

    task automatic test_zero_and_bubble();
        do_reset();
        set_id(OP_RTYPE, 5'd0, 5'd0);
        ex_mem_read = 1'b1;  ex_wr_reg = 5'd0;
        #1;
        tests++;
        if (outs !== O_RUN) begin
            failures++;
            $display("FAIL zero_reg_load: got %b want %b", outs, O_RUN);
        end
        set_id(OP_BEQ, 5'd0, 5'd0);
        branch_equal = 1'b1;
        ex_mem_read = 1'b0;  ex_reg_write = 1'b1;
        #1;
        tests++;
        if (outs !== O_BR) begin
            failures++;
            $display("FAIL zero_reg_branch: got %b want %b", outs, O_BR);
        end
        clear_inputs();
        id_op = OP_RTYPE; id_rs = 5'd8;
        ex_mem_read = 1'b1;  ex_wr_reg = 5'd8;
        #1;
        tests++;
        if (outs !== O_RUN) begin
            failures++;
            $display("FAIL bubble_no_stall: got %b want %b", outs, O_RUN);
        end
        clear_inputs();
        id_op = OP_J;
        #1;
        tests++;
        if (outs !== O_RUN) begin
            failures++;
            $display("FAIL bubble_no_jump: got %b want %b", outs, O_RUN);
        end
    endtask

    task automatic test_jump_saturate();
        do_reset();
        set_id(OP_J, 5'd8, 5'd8);
        ex_mem_read = 1'b1;  ex_wr_reg = 5'd8;
        #1;
        tests++;
        if (outs !== O_JMP) begin
            failures++;
            $display("FAIL j_taken: got %b want %b", outs, O_JMP);
        end
        clear_inputs();
        set_id(OP_JAL, 5'd0, 5'd0);
        #1;
        tests++;
        if (outs !== O_JMP) begin
            failures++;
            $display("FAIL jal_taken: got %b want %b", outs, O_JMP);
        end
        for (int i = 0; i < 65534; i++) tick();
        tests++;
        if (flush_count !== 16'hFFFE) begin
            failures++;
            $display("FAIL flush_pre_sat: got %h want fffe", flush_count);
        end
        for (int i = 0; i < 4466; i++) tick();
        tests++;
        if (flush_count !== 16'hFFFF || stall_cycles !== 16'd0) begin
            failures++;
            $display("FAIL flush_saturate: got %h/%0d want ffff/0", flush_count, stall_cycles);
        end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        set_id(OP_BEQ, 5'd9, 5'd2);
        ex_mem_read = 1'b1;  ex_wr_reg = 5'd9;
        tick();
        ex_mem_read = 1'b0;  ex_wr_reg = 5'd0;
        #1;
        rst = 1'b0;
        #1;
        tests++;
        if (outs !== O_RST) begin
            failures++;
            $display("FAIL hold_reset_outs: got %b want %b", outs, O_RST);
        end
        tests++;
        if (stall_cycles !== 16'd0) begin
            failures++;
            $display("FAIL hold_reset_count: got %0d want 0", stall_cycles);
        end
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if (outs !== O_RUN) begin
            failures++;
            $display("FAIL hold_reset_run: got %b want %b", outs, O_RUN);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_branch();
        test_alu_branch();
        test_zero_and_bubble();
        test_jump_saturate();
        test_reset_in_hold();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It watches the instruction in ID and the destination registers of the EX and MEM stages, and drives the stall/enable/flush controls for the PC, IF/ID and ID/EX registers. It resolves branches in ID using the register-file equality flag, and keeps saturating performance counters for stall cycles and flushes.

## Interface
- No parameters; all widths are fixed by the ISA.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction (0 = bubble)
- id_op  in  6  ID opcode [31:26]
- id_rs, id_rt  in  5 each  ID source fields [25:21], [20:16]
- branch_equal  in  1  RD1 == RD2 from ID register read
- ex_mem_read, ex_reg_write  in  1 each  EX-stage load / register-writing instruction
- ex_wr_reg  in  5  EX-stage destination register
- mem_mem_read  in  1  MEM-stage load
- mem_wr_reg  in  5  MEM-stage destination register
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  zero the IF/ID register at the next edge
- idex_bubble  out  1  load a NOP into ID/EX
- branch_taken, jump_taken  out  1 each  redirect the PC to the branch/jump target
- stall_cycles  out  16  saturating count of stalled cycles
- flush_count  out  16  saturating count of flushes

## Operation
- Opcodes: R-type 0x00, j 0x02, jal 0x03, beq 0x04, bne 0x05, lui 0x0F, sw 0x2B.
- uses_rs: every opcode except j, jal and lui.
- uses_rt: R-type, beq, bne and sw.
- A match requires a source field equal to the destination register, with the matching use flag set and the destination not equal to 0.
- Stall length n is evaluated only when id_valid = 1. Highest rule wins:
  - Branch (beq/bne) that matches EX with ex_mem_read = 1 → n = 2.
  - Branch that matches EX with ex_reg_write = 1, or matches MEM with mem_mem_read = 1 → n = 1.
  - Non-branch that matches EX with ex_mem_read = 1 → n = 1.
  - Otherwise n = 0.
- States: RUN and HOLD.
  - RUN with n > 0: stall this cycle. Go to HOLD if n = 2; stay in RUN if n = 1, so the hazard is re-evaluated next cycle.
  - HOLD: stall unconditionally for one cycle, then go to RUN. Inputs are ignored while in HOLD.
- A stall drives pc_write = 0, ifid_write = 0 and idex_bubble = 1, with branch_taken, jump_taken and ifid_flush all 0.
- In RUN with n = 0:
  - pc_write = ifid_write = 1 and idex_bubble = 0.
  - beq with branch_equal = 1, or bne with branch_equal = 0 → branch_taken = 1 and ifid_flush = 1.
  - j or jal → jump_taken = 1 and ifid_flush = 1.
- A stall always takes priority over branch or jump resolution. The branch is resolved in the first cycle that is not stalled.
- stall_cycles increments on every stall cycle and flush_count on every cycle with ifid_flush = 1. Both hold at 0xFFFF once saturated.

## Timing
- All control outputs are Mealy outputs: combinational from state and current inputs, valid in the same cycle the hazard is present.
- State and counters update on the rising edge of clk.
- While rst = 0, regardless of state:
  - state = RUN and both counters = 0.
  - pc_write = 0, ifid_write = 0, idex_bubble = 1; ifid_flush, branch_taken and jump_taken = 0.
- Reset asserted mid-HOLD aborts the stall immediately. The first cycle after release evaluates in RUN.
- When id_valid = 0, n = 0 and there is no branch or jump action; outputs are pc_write = ifid_write = 1 with everything else 0.
- Source or destination register $0 never causes a stall.

## Structure
- Shared package mips_pkg holds the opcode localparams, the RUN/HOLD state encoding and the 16-bit counter width.
- Sub-module hazard_detect is purely combinational: it takes the ID fields and the EX/MEM destinations and returns n[1:0]. hazard_ctrl holds the FSM, the output logic and the counters.

## Test plan
- Load-use: EX is lw to $8 (ex_mem_read = 1, ex_wr_reg = 8), ID is add with rs = 8 → one stall cycle (pc_write = 0, idex_bubble = 1), then a normal cycle after the load moves on; stall_cycles = 1.
- Load then branch: EX lw to $9, ID beq rs = 9 → stall for 2 cycles (RUN→HOLD→RUN), then branch_equal = 1 → branch_taken = 1, ifid_flush = 1; stall_cycles = 2, flush_count = 1.
- ALU result feeding a branch: EX writes $3, ID bne rt = 3 → 1 stall; next cycle with branch_equal = 1 → no redirect, flush_count unchanged.
- $0 and bubble cases: ex_wr_reg = 0 with a load and ID rs = 0 → no stall; id_valid = 0 during a matching load → no stall.
- Jump and counters: j in ID → jump_taken = 1 and ifid_flush = 1 in the same cycle; force 70000 flushes → flush_count holds at 0xFFFF.
- Reset during HOLD: rst = 0 asynchronously → outputs take reset values immediately and counters read 0; after release, state is RUN.
